// File: rtl/phase_sequencer.sv
// phase_sequencer: four-phase machine-cycle timing generator with a one-hot
// instruction step vector and run / halt / single-step control.
module phase_sequencer #(
  parameter int NUM_STEPS = 6,
  parameter int DIV       = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 halt_req,
  input  logic                 step_req,
  input  logic                 restart,
  output logic                 clk_out,
  output logic                 clk_en,
  output logic                 clk_set,
  output logic [NUM_STEPS-1:0] step,
  output logic                 running,
  output logic                 cycle_done
);

  typedef enum logic [1:0] {IDLE, RUN, SINGLE} state_t;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  localparam logic [7:0]           PRESC_MAX  = 8'(DIV - 1);
  localparam logic [NUM_STEPS-1:0] STEP_FIRST = NUM_STEPS'(1);

  state_t               state, state_n;
  logic [1:0]           phase, phase_n;
  logic [7:0]           presc, presc_n;
  logic [NUM_STEPS-1:0] step_n;
  logic                 halt_pending, halt_n;
  logic                 cd_n;
  logic                 tick, boundary;

  // Next-state: phase/prescaler advance, step rotation, run/halt/single control.
  always_comb begin
    state_n  = state;
    phase_n  = phase;
    presc_n  = presc;
    step_n   = step;
    halt_n   = halt_pending;
    cd_n     = 1'b0;
    tick     = (presc == PRESC_MAX);
    boundary = (state != IDLE) && (phase == P3) && tick;

    case (state)
      IDLE: begin
        presc_n = '0;
        phase_n = P3;
        if (run) begin
          state_n = RUN;
          phase_n = P0;
        end else if (step_req) begin
          state_n = SINGLE;
          phase_n = P0;
        end
      end
      default: begin
        if (halt_req) halt_n = 1'b1;
        if (tick) begin
          presc_n = '0;
          phase_n = phase + 2'd1;
        end else begin
          presc_n = presc + 8'd1;
        end
        if (boundary) begin
          // The top step never rotates out to zero: it always wraps to step[0].
          if (restart || step[NUM_STEPS-1]) begin
            step_n = STEP_FIRST;
            cd_n   = 1'b1;
          end else begin
            step_n = step << 1;
          end
          if (state == SINGLE || halt_pending || !run) begin
            state_n = IDLE;
            phase_n = P3;
          end
        end
      end
    endcase

    // Entering IDLE drops any queued halt and parks the prescaler.
    if (state_n == IDLE && state != IDLE) begin
      halt_n  = 1'b0;
      presc_n = '0;
    end
  end

  // Core sequencer state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= P3;
      presc        <= '0;
      step         <= STEP_FIRST;
      halt_pending <= 1'b0;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      presc        <= presc_n;
      step         <= step_n;
      halt_pending <= halt_n;
    end
  end

  // Registered strobes decoded from next-state values, so they line up with phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_out    <= 1'b0;
      clk_en     <= 1'b0;
      clk_set    <= 1'b0;
      running    <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      clk_out    <= (state_n != IDLE) && (phase_n == P0 || phase_n == P1);
      clk_en     <= (state_n != IDLE) && (phase_n != P3);
      clk_set    <= (state_n != IDLE) && (phase_n == P1);
      running    <= (state_n != IDLE);
      cycle_done <= cd_n;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed tests for phase_sequencer at DIV=1 and DIV=3.
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0, halt_req = 1'b0, step_req = 1'b0, restart = 1'b0;
  logic clk_out, clk_en, clk_set, running, cycle_done;
  logic [5:0] step;

  logic run3 = 1'b0, halt3 = 1'b0, sreq3 = 1'b0, restart3 = 1'b0;
  logic clk_out3, clk_en3, clk_set3, running3, cycle_done3;
  logic [5:0] step3;

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe pattern {clk_out, clk_en, clk_set} for phases P0..P3.
  logic [2:0] pat [4] = '{3'b110, 3'b111, 3'b010, 3'b000};

  phase_sequencer #(.NUM_STEPS(6), .DIV(1)) dut (
    .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .step_req(step_req),
    .restart(restart), .clk_out(clk_out), .clk_en(clk_en), .clk_set(clk_set),
    .step(step), .running(running), .cycle_done(cycle_done));

  phase_sequencer #(.NUM_STEPS(6), .DIV(3)) dut3 (
    .clk(clk), .rst(rst), .run(run3), .halt_req(halt3), .step_req(sreq3),
    .restart(restart3), .clk_out(clk_out3), .clk_en(clk_en3), .clk_set(clk_set3),
    .step(step3), .running(running3), .cycle_done(cycle_done3));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; halt_req = 1'b0; step_req = 1'b0; restart = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    run = 1'b1;
    cyc(); cyc();
    n_checks++; if ({clk_out, clk_en, clk_set} !== 3'b111) begin n_fail++; $display("FAIL reset_pre_p1 strobes got %b want 111", {clk_out, clk_en, clk_set}); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({clk_out, clk_en, clk_set} !== 3'b000) begin n_fail++; $display("FAIL reset_async strobes got %b want 000", {clk_out, clk_en, clk_set}); end
    n_checks++; if (step !== 6'b000001) begin n_fail++; $display("FAIL reset_async step got %b want 000001", step); end
    n_checks++; if ({running, cycle_done} !== 2'b00) begin n_fail++; $display("FAIL reset_async running/cd got %b want 00", {running, cycle_done}); end
    run = 1'b0;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_checks++; if ({clk_out, clk_en, clk_set, running, cycle_done, step} !== 11'b00000_000001) begin n_fail++; $display("FAIL idle_stable cyc %0d got %b want 00000000001", i, {clk_out, clk_en, clk_set, running, cycle_done, step}); end
    end
  endtask

  // Free run from step[0]; leaves the DUT observed at P1 of step[2] (k=57).
  task automatic test_free_run();
    logic [5:0] es;
    run = 1'b1;
    for (int k = 0; k <= 57; k++) begin
      cyc();
      es = 6'b000001 << ((k / 4) % 6);
      n_checks++; if ({clk_out, clk_en, clk_set} !== pat[k % 4]) begin n_fail++; $display("FAIL run_strobes k=%0d got %b want %b", k, {clk_out, clk_en, clk_set}, pat[k % 4]); end
      n_checks++; if (step !== es) begin n_fail++; $display("FAIL run_step k=%0d got %b want %b", k, step, es); end
      n_checks++; if (cycle_done !== (k == 24 || k == 48)) begin n_fail++; $display("FAIL run_cycle_done k=%0d got %b want %b", k, cycle_done, (k == 24 || k == 48)); end
      n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL run_running k=%0d got %b want 1", k, running); end
    end
  endtask

  task automatic test_halt();
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    n_checks++; if ({clk_out, clk_en, clk_set} !== 3'b010) begin n_fail++; $display("FAIL halt_p2 got %b want 010", {clk_out, clk_en, clk_set}); end
    cyc();
    n_checks++; if ({clk_out, clk_en, clk_set, running} !== 4'b0001) begin n_fail++; $display("FAIL halt_p3 got %b want 0001", {clk_out, clk_en, clk_set, running}); end
    n_checks++; if (step !== 6'b000100) begin n_fail++; $display("FAIL halt_p3_step got %b want 000100", step); end
    cyc();
    // run still high at the boundary: only the pending halt sends it to IDLE.
    n_checks++; if ({clk_out, clk_en, clk_set, running, cycle_done} !== 5'b00000) begin n_fail++; $display("FAIL halt_idle got %b want 00000", {clk_out, clk_en, clk_set, running, cycle_done}); end
    n_checks++; if (step !== 6'b001000) begin n_fail++; $display("FAIL halt_idle_step got %b want 001000", step); end
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_checks++; if ({clk_out, clk_en, clk_set, running, step} !== 10'b0000_001000) begin n_fail++; $display("FAIL halt_quiet cyc %0d got %b want 0000001000", i, {clk_out, clk_en, clk_set, running, step}); end
    end
  endtask

  task automatic test_single_step();
    logic [5:0] es;
    do_reset();
    for (int b = 0; b < 3; b++) begin
      step_req = 1'b1;
      cyc();
      step_req = 1'b0;
      es = 6'b000001 << b;
      for (int k = 0; k < 4; k++) begin
        n_checks++; if ({clk_out, clk_en, clk_set, running} !== {pat[k], 1'b1}) begin n_fail++; $display("FAIL single_burst b=%0d k=%0d got %b want %b", b, k, {clk_out, clk_en, clk_set, running}, {pat[k], 1'b1}); end
        n_checks++; if (step !== es) begin n_fail++; $display("FAIL single_step b=%0d k=%0d got %b want %b", b, k, step, es); end
        step_req = (b == 1 && k == 1);
        cyc();
        step_req = 1'b0;
      end
      es = 6'b000010 << b;
      for (int i = 0; i < 5; i++) begin
        n_checks++; if ({clk_out, clk_en, clk_set, running, step} !== {4'b0000, es}) begin n_fail++; $display("FAIL single_idle b=%0d i=%0d got %b want %b", b, i, {clk_out, clk_en, clk_set, running, step}, {4'b0000, es}); end
        if (i < 4) cyc();
      end
    end
  endtask

  task automatic test_restart();
    do_reset();
    run = 1'b1;
    for (int k = 0; k <= 15; k++) cyc();
    n_checks++; if ({clk_out, clk_en, clk_set, step} !== 9'b000_001000) begin n_fail++; $display("FAIL restart_pre got %b want 000001000", {clk_out, clk_en, clk_set, step}); end
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    run = 1'b0;
    n_checks++; if ({clk_out, clk_en, clk_set, cycle_done, step} !== 10'b1101_000001) begin n_fail++; $display("FAIL restart_wrap got %b want 1101000001", {clk_out, clk_en, clk_set, cycle_done, step}); end
    cyc();
    n_checks++; if ({clk_out, clk_en, clk_set, cycle_done} !== 4'b1110) begin n_fail++; $display("FAIL restart_cd_pulse got %b want 1110", {clk_out, clk_en, clk_set, cycle_done}); end
    cyc(); cyc(); cyc();
    n_checks++; if ({running, cycle_done, step} !== 8'b00_000010) begin n_fail++; $display("FAIL restart_stop got %b want 00000010", {running, cycle_done, step}); end
  endtask

  task automatic test_prescale();
    run3 = 1'b1;
    cyc();
    run3 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      n_checks++; if ({clk_out3, clk_en3, clk_set3, running3} !== {pat[k / 3], 1'b1}) begin n_fail++; $display("FAIL div3_strobes k=%0d got %b want %b", k, {clk_out3, clk_en3, clk_set3, running3}, {pat[k / 3], 1'b1}); end
      n_checks++; if (step3 !== 6'b000001) begin n_fail++; $display("FAIL div3_step k=%0d got %b want 000001", k, step3); end
      cyc();
    end
    n_checks++; if ({clk_out3, clk_en3, clk_set3, running3, cycle_done3, step3} !== 11'b00000_000010) begin n_fail++; $display("FAIL div3_end got %b want 00000000010", {clk_out3, clk_en3, clk_set3, running3, cycle_done3, step3}); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_halt();
    test_single_step();
    test_restart();
    test_prescale();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
